// File: rtl/ucsbece154b_fetch_pkg.sv
// ucsbece154b_fetch_pkg: fetch FSM state encodings, reset PC and NOP encoding shared by the fetch stage
package ucsbece154b_fetch_pkg;
  typedef enum logic [1:0] {FETCH_REQ, FETCH_WAIT, FETCH_DROP, FETCH_HOLD} fetch_state_e;
  localparam logic [31:0] RESET_PC_DEF = 32'h0001_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
endpackage

// File: rtl/ucsbece154b_ifid_reg.sv
// ucsbece154b_ifid_reg: IF/ID register (flush > stall > load > bubble); ports: clk/reset, flush/stall/load controls, instr/pc/pc+4 in, instr/pc/pc+4/valid out
import ucsbece154b_fetch_pkg::*;
module ucsbece154b_ifid_reg #(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pcplus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pcplus4_o,
  output logic        valid_o
);
  logic [31:0] r_instr, r_pc, r_pcplus4;
  logic        r_valid;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_instr   <= NOP_INSTR;
      r_pc      <= '0;
      r_pcplus4 <= '0;
      r_valid   <= 1'b0;
    end else if (flush_i) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (!stall_i) begin
      r_instr <= load_i ? instr_i : NOP_INSTR;
      r_valid <= load_i;
      if (load_i) begin
        r_pc      <= pc_i;
        r_pcplus4 <= pcplus4_i;
      end
    end
  assign instr_o   = r_instr;
  assign pc_o      = r_pc;
  assign pcplus4_o = r_pcplus4;
  assign valid_o   = r_valid;
endmodule

// File: rtl/ucsbece154b_fetch.sv
// ucsbece154b_fetch: PCF, single-outstanding imem request FSM with stale-response drop and stall hold buffer, feeding IF/ID and decode fields
import ucsbece154b_fetch_pkg::*;
module ucsbece154b_fetch #(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF_i,
  input  logic        StallD_i,
  input  logic        FlushD_i,
  input  logic        PCSrcE_i,
  input  logic [31:0] PCTargetE_i,
  output logic        IMemReq_o,
  output logic [31:0] IMemAddr_o,
  input  logic [31:0] IMemRdata_i,
  input  logic        IMemValid_i,
  output logic [31:0] InstrD_o,
  output logic [31:0] PCD_o,
  output logic [31:0] PCPlus4D_o,
  output logic        ValidD_o,
  output logic [6:0]  op_o,
  output logic [2:0]  funct3_o,
  output logic        funct7b5_o,
  output logic [4:0]  Rs1D_o,
  output logic [4:0]  Rs2D_o,
  output logic [4:0]  RdD_o
);
  fetch_state_e r_state, w_state_n;
  logic [31:0]  r_pcf, w_pcf_n, r_hold, w_hold_n, w_dinstr;
  logic         w_stall, w_deliver;
  assign w_stall = StallF_i | StallD_i;
  always_comb begin
    w_state_n = r_state;
    w_pcf_n   = r_pcf;
    w_hold_n  = r_hold;
    w_deliver = 1'b0;
    w_dinstr  = IMemRdata_i;
    unique case (r_state)
      FETCH_REQ:
        if (PCSrcE_i) w_pcf_n = PCTargetE_i;
        else w_state_n = FETCH_WAIT;
      FETCH_WAIT:
        if (PCSrcE_i) begin
          w_pcf_n   = PCTargetE_i;
          w_state_n = IMemValid_i ? FETCH_REQ : FETCH_DROP;
        end else if (IMemValid_i && w_stall) begin
          w_hold_n  = IMemRdata_i;
          w_state_n = FETCH_HOLD;
        end else if (IMemValid_i) begin
          w_deliver = 1'b1;
          w_state_n = FETCH_REQ;
        end
      FETCH_DROP: begin
        if (PCSrcE_i) w_pcf_n = PCTargetE_i;
        if (IMemValid_i) w_state_n = FETCH_REQ;
      end
      FETCH_HOLD: begin
        w_dinstr = r_hold;
        if (PCSrcE_i) begin
          w_hold_n  = '0;
          w_pcf_n   = PCTargetE_i;
          w_state_n = FETCH_REQ;
        end else if (!w_stall) begin
          w_deliver = 1'b1;
          w_state_n = FETCH_REQ;
        end
      end
    endcase
    if (w_deliver) w_pcf_n = r_pcf + 32'd4;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= FETCH_REQ;
      r_pcf   <= RESET_PC;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_n;
      r_pcf   <= w_pcf_n;
      r_hold  <= w_hold_n;
    end
  assign IMemReq_o  = (r_state == FETCH_REQ) && !PCSrcE_i && !reset;
  assign IMemAddr_o = r_pcf;
  ucsbece154b_ifid_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (FlushD_i),
    .stall_i   (StallD_i),
    .load_i    (w_deliver),
    .instr_i   (w_dinstr),
    .pc_i      (r_pcf),
    .pcplus4_i (r_pcf + 32'd4),
    .instr_o   (InstrD_o),
    .pc_o      (PCD_o),
    .pcplus4_o (PCPlus4D_o),
    .valid_o   (ValidD_o)
  );
  assign op_o       = InstrD_o[6:0];
  assign funct3_o   = InstrD_o[14:12];
  assign funct7b5_o = InstrD_o[30];
  assign Rs1D_o     = InstrD_o[19:15];
  assign Rs2D_o     = InstrD_o[24:20];
  assign RdD_o      = InstrD_o[11:7];
endmodule

// File: tb/tb_ucsbece154b_fetch.sv
// tb_ucsbece154b_fetch: directed scenarios plus randomized traffic against a transaction-level fetch model
module tb_ucsbece154b_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, reset = 1'b0;
  logic StallF_i = 1'b0, StallD_i = 1'b0, FlushD_i = 1'b0, PCSrcE_i = 1'b0, IMemValid_i = 1'b0;
  logic [31:0] PCTargetE_i = '0, IMemRdata_i = '0;
  logic IMemReq_o, ValidD_o, funct7b5_o;
  logic [31:0] IMemAddr_o, InstrD_o, PCD_o, PCPlus4D_o;
  logic [6:0] op_o;
  logic [2:0] funct3_o;
  logic [4:0] Rs1D_o, Rs2D_o, RdD_o;
  ucsbece154b_fetch dut (
    .clk(clk), .reset(reset), .StallF_i(StallF_i), .StallD_i(StallD_i), .FlushD_i(FlushD_i),
    .PCSrcE_i(PCSrcE_i), .PCTargetE_i(PCTargetE_i), .IMemReq_o(IMemReq_o), .IMemAddr_o(IMemAddr_o),
    .IMemRdata_i(IMemRdata_i), .IMemValid_i(IMemValid_i), .InstrD_o(InstrD_o), .PCD_o(PCD_o),
    .PCPlus4D_o(PCPlus4D_o), .ValidD_o(ValidD_o), .op_o(op_o), .funct3_o(funct3_o),
    .funct7b5_o(funct7b5_o), .Rs1D_o(Rs1D_o), .Rs2D_o(Rs2D_o), .RdD_o(RdD_o)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  // model: pending fetch bookkeeping in terms of transactions, not FSM states
  logic [31:0] m_pc, m_hold, e_instr, e_pc, e_pc4;
  bit m_out, m_stale, m_hv, e_valid;
  int mem_cnt, lat_min, lat_max;
  logic [31:0] mem_addr;
  logic rst_req;
  logic o_req, x_req;
  logic [31:0] o_addr, x_addr;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [29:0] h;
    h = a[31:2] ^ 30'h1234567;
    return a == 32'h10000 ? 32'h00500093 : a == 32'h10004 ? 32'h00100113 : {h, 2'b11};
  endfunction
  task automatic apply_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    StallF_i = 0; StallD_i = 0; FlushD_i = 0; PCSrcE_i = 0; IMemValid_i = 0;
    #1 rst_req = IMemReq_o;
    m_pc = 32'h10000; m_out = 0; m_stale = 0; m_hv = 0; m_hold = '0;
    e_instr = NOP; e_pc = '0; e_pc4 = '0; e_valid = 0; mem_cnt = 0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask
  task automatic step(input logic sf, sd, fl, rd, input logic [31:0] tg, input logic fv);
    logic v, dlv;
    logic [31:0] rdata, dins, dpc;
    @(negedge clk);
    StallF_i = sf; StallD_i = sd; FlushD_i = fl; PCSrcE_i = rd; PCTargetE_i = tg;
    v = fv | (mem_cnt == 1);
    rdata = (mem_cnt == 1) ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    IMemValid_i = v; IMemRdata_i = rdata;
    #1 o_req = IMemReq_o; o_addr = IMemAddr_o;
    x_req = !m_out && !m_hv && !rd; x_addr = m_pc;
    @(posedge clk);
    dlv = 0; dins = '0; dpc = '0;
    if (m_hv) begin
      if (rd) begin m_hv = 0; m_pc = tg; end
      else if (!(sf | sd)) begin dlv = 1; dins = m_hold; m_hv = 0; end
    end else if (!m_out) begin
      if (rd) m_pc = tg; else begin m_out = 1; m_stale = 0; end
    end else if (m_stale) begin
      if (rd) m_pc = tg;
      if (v) m_out = 0;
    end else if (rd) begin
      m_pc = tg;
      if (v) m_out = 0; else m_stale = 1;
    end else if (v) begin
      m_out = 0;
      if (sf | sd) begin m_hv = 1; m_hold = rdata; end
      else begin dlv = 1; dins = rdata; end
    end
    if (dlv) begin dpc = m_pc; m_pc = m_pc + 32'd4; end
    if (fl) begin e_instr = NOP; e_valid = 0; end
    else if (!sd) begin
      e_valid = dlv;
      e_instr = dlv ? dins : NOP;
      if (dlv) begin e_pc = dpc; e_pc4 = dpc + 32'd4; end
    end
    if (mem_cnt > 0) mem_cnt--;
    if (o_req) begin mem_cnt = $urandom_range(lat_max, lat_min); mem_addr = o_addr; end
    #1;
  endtask
  task automatic test_reset();
    apply_reset();
    checks += 6;
    if (rst_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", rst_req); end
    if (InstrD_o !== NOP) begin errors++; $display("FAIL reset_instr got=%h exp=%h", InstrD_o, NOP); end
    if (PCD_o !== 32'h0) begin errors++; $display("FAIL reset_pcd got=%h exp=0", PCD_o); end
    if (PCPlus4D_o !== 32'h0) begin errors++; $display("FAIL reset_pc4 got=%h exp=0", PCPlus4D_o); end
    if (ValidD_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ValidD_o); end
    if (IMemAddr_o !== 32'h10000) begin errors++; $display("FAIL reset_addr got=%h exp=10000", IMemAddr_o); end
  endtask
  task automatic test_basic();
    apply_reset(); lat_min = 1; lat_max = 1;
    step(0, 0, 0, 0, '0, 0);
    checks++;
    if (o_req !== 1'b1 || o_addr !== 32'h10000) begin errors++; $display("FAIL basic_req0 got=%b/%h exp=1/10000", o_req, o_addr); end
    step(0, 0, 0, 0, '0, 0);
    checks += 2;
    if ({InstrD_o, PCD_o, PCPlus4D_o, ValidD_o} !== {32'h00500093, 32'h10000, 32'h10004, 1'b1}) begin
      errors++; $display("FAIL basic_d0 got=%h/%h/%h/%b exp=00500093/10000/10004/1", InstrD_o, PCD_o, PCPlus4D_o, ValidD_o);
    end
    if (RdD_o !== 5'd1) begin errors++; $display("FAIL basic_rd got=%0d exp=1", RdD_o); end
    step(0, 0, 0, 0, '0, 0);
    checks += 2;
    if (o_req !== 1'b1 || o_addr !== 32'h10004) begin errors++; $display("FAIL basic_req1 got=%b/%h exp=1/10004", o_req, o_addr); end
    if (ValidD_o !== 1'b0) begin errors++; $display("FAIL basic_bubble got=%b exp=0", ValidD_o); end
    step(0, 0, 0, 0, '0, 0);
    checks++;
    if (InstrD_o !== 32'h00100113 || ValidD_o !== 1'b1) begin errors++; $display("FAIL basic_d1 got=%h/%b exp=00100113/1", InstrD_o, ValidD_o); end
  endtask
  task automatic test_redirect();
    apply_reset(); lat_min = 3; lat_max = 3;
    step(0, 0, 0, 0, '0, 0);
    step(0, 0, 0, 0, '0, 0);
    step(0, 0, 1, 1, 32'h10040, 0);
    step(0, 0, 0, 0, '0, 0);
    checks++;
    if (ValidD_o !== 1'b0) begin errors++; $display("FAIL redir_discard got=%b exp=0", ValidD_o); end
    step(0, 0, 0, 0, '0, 0);
    checks += 2;
    if (o_req !== 1'b1 || o_addr !== 32'h10040) begin errors++; $display("FAIL redir_addr got=%b/%h exp=1/10040", o_req, o_addr); end
    if (ValidD_o !== 1'b0) begin errors++; $display("FAIL redir_valid got=%b exp=0", ValidD_o); end
  endtask
  task automatic test_stall();
    apply_reset(); lat_min = 1; lat_max = 1;
    step(0, 0, 0, 0, '0, 0);
    step(1, 1, 0, 0, '0, 0);
    checks++;
    if (InstrD_o !== NOP || ValidD_o !== 1'b0) begin errors++; $display("FAIL stall_hold0 got=%h/%b exp=%h/0", InstrD_o, ValidD_o, NOP); end
    step(1, 1, 0, 0, '0, 0);
    checks += 2;
    if (o_req !== 1'b0) begin errors++; $display("FAIL stall_noreq got=%b exp=0", o_req); end
    if (InstrD_o !== NOP || ValidD_o !== 1'b0) begin errors++; $display("FAIL stall_hold1 got=%h/%b exp=%h/0", InstrD_o, ValidD_o, NOP); end
    step(0, 0, 0, 0, '0, 0);
    checks += 2;
    if (o_req !== 1'b0) begin errors++; $display("FAIL stall_rel_req got=%b exp=0", o_req); end
    if (InstrD_o !== 32'h00500093 || ValidD_o !== 1'b1) begin errors++; $display("FAIL stall_deliver got=%h/%b exp=00500093/1", InstrD_o, ValidD_o); end
    step(0, 0, 0, 0, '0, 0);
    checks++;
    if (o_req !== 1'b1 || o_addr !== 32'h10004) begin errors++; $display("FAIL stall_next got=%b/%h exp=1/10004", o_req, o_addr); end
  endtask
  task automatic test_flush_stall();
    step(0, 1, 1, 1, 32'h10100, 0);
    checks += 2;
    if (InstrD_o !== NOP || ValidD_o !== 1'b0) begin errors++; $display("FAIL flush_bubble got=%h/%b exp=%h/0", InstrD_o, ValidD_o, NOP); end
    if (PCD_o !== 32'h10000) begin errors++; $display("FAIL flush_pcd got=%h exp=10000", PCD_o); end
  endtask
  task automatic test_wrap();
    apply_reset(); lat_min = 1; lat_max = 1;
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    checks++;
    if (o_req !== 1'b0) begin errors++; $display("FAIL wrap_redir_req got=%b exp=0", o_req); end
    step(0, 0, 0, 0, '0, 0);
    checks++;
    if (o_req !== 1'b1 || o_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req got=%b/%h exp=1/fffffffc", o_req, o_addr); end
    step(0, 0, 0, 0, '0, 0);
    checks++;
    if (PCD_o !== 32'hFFFF_FFFC || PCPlus4D_o !== 32'h0 || ValidD_o !== 1'b1) begin
      errors++; $display("FAIL wrap_d got=%h/%h/%b exp=fffffffc/0/1", PCD_o, PCPlus4D_o, ValidD_o);
    end
    step(0, 0, 0, 0, '0, 0);
    checks++;
    if (o_req !== 1'b1 || o_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got=%b/%h exp=1/0", o_req, o_addr); end
  endtask
  task automatic test_reset_mid_wait();
    bit seen, early;
    apply_reset(); lat_min = 3; lat_max = 3;
    step(0, 0, 0, 0, '0, 0);
    step(0, 0, 0, 0, '0, 0);
    apply_reset();
    checks++;
    if (rst_req !== 1'b0) begin errors++; $display("FAIL midwait_rst_req got=%b exp=0", rst_req); end
    step(0, 0, 0, 0, '0, 1);
    checks += 2;
    if (o_req !== 1'b1 || o_addr !== 32'h10000) begin errors++; $display("FAIL midwait_addr got=%b/%h exp=1/10000", o_req, o_addr); end
    if (ValidD_o !== 1'b0) begin errors++; $display("FAIL midwait_ignore got=%b exp=0", ValidD_o); end
    seen = 0; early = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(0, 0, 0, 0, '0, 0);
      if (ValidD_o === 1'b1) seen = 1;
      else if (mem_cnt == 0 && !seen && i > 4) early = 1;
    end
    checks += 2;
    if (!seen || early) begin errors++; $display("FAIL midwait_timeout got=seen%b exp=seen1", seen); end
    if (InstrD_o !== 32'h00500093) begin errors++; $display("FAIL midwait_instr got=%h exp=00500093", InstrD_o); end
  endtask
  task automatic test_random();
    logic rd;
    apply_reset(); lat_min = 1; lat_max = 4;
    for (int i = 0; i < 400; i++) begin
      rd = ($urandom_range(0, 11) == 0);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, rd & $urandom_range(0, 1),
           rd, $urandom & 32'hFFFF_FFFC, 0);
      checks += 3;
      if (o_req !== x_req || (x_req && o_addr !== x_addr)) begin
        errors++; $display("FAIL rnd_req cyc=%0d got=%b/%h exp=%b/%h", i, o_req, o_addr, x_req, x_addr);
      end
      if ({InstrD_o, PCD_o, PCPlus4D_o, ValidD_o} !== {e_instr, e_pc, e_pc4, e_valid}) begin
        errors++; $display("FAIL rnd_ifid cyc=%0d got=%h/%h/%h/%b exp=%h/%h/%h/%b", i,
                           InstrD_o, PCD_o, PCPlus4D_o, ValidD_o, e_instr, e_pc, e_pc4, e_valid);
      end
      if ({op_o, funct3_o, funct7b5_o, Rs1D_o, Rs2D_o, RdD_o} !==
          {e_instr[6:0], e_instr[14:12], e_instr[30], e_instr[19:15], e_instr[24:20], e_instr[11:7]}) begin
        errors++; $display("FAIL rnd_fields cyc=%0d instr=%h got op=%h f3=%h", i, e_instr, op_o, funct3_o);
      end
    end
  endtask
  initial begin
    lat_min = 1; lat_max = 1; mem_cnt = 0; mem_addr = '0;
    test_reset();
    test_basic();
    test_redirect();
    test_stall();
    test_flush_stall();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ucsbece154b_fetch.md
Name: ucsbece154b_fetch

Overview:
Instruction-fetch stage and IF/ID pipeline register of the 5-stage RISC-V core, directly upstream of the controller/decode stage. Holds PCF, issues requests to a variable-latency instruction memory with at most one outstanding request, and discards responses made stale by a taken branch or jump. Drives the decode-stage instruction fields (op, funct3, funct7b5, Rs1D, Rs2D, RdD). Inserts a NOP bubble into decode whenever no fetched instruction is ready, so the hazard logic needs no memory-latency awareness.

Parameters:
RESET_PC, 32'h0001_0000, PCF value loaded on reset.
NOP_INSTR, 32'h0000_0013, encoding of addi x0,x0,0 used for bubbles.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
StallF_i  in  1  hold PCF; no new delivery into IF/ID
StallD_i  in  1  hold IF/ID contents
FlushD_i  in  1  load bubble into IF/ID
PCSrcE_i  in  1  taken branch/jump redirect in Execute
PCTargetE_i  in  32  redirect target
IMemReq_o  out  1  request strobe, one cycle per request
IMemAddr_o  out  32  request address (= PCF)
IMemRdata_i  in  32  returned instruction
IMemValid_i  in  1  response strobe, one cycle; latency >= 1 cycle after request
InstrD_o  out  32  IF/ID instruction
PCD_o  out  32  IF/ID PC
PCPlus4D_o  out  32  IF/ID PC+4
ValidD_o  out  1  1 = real instruction, 0 = bubble
op_o  out  7  InstrD[6:0]
funct3_o  out  3  InstrD[14:12]
funct7b5_o  out  1  InstrD[30]
Rs1D_o  out  5  InstrD[19:15]
Rs2D_o  out  5  InstrD[24:20]
RdD_o  out  5  InstrD[11:7]

Behaviour:
- Reset (async, any state): PCF=RESET_PC, state=REQ, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, hold buffer cleared. IMemReq_o=0 while reset is high.
- Stall = StallF_i | StallD_i. Redirect = PCSrcE_i; redirect has priority over every other event.
- Field outputs are pure combinational slices of InstrD. All PC arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- REQ: IMemReq_o=1, IMemAddr_o=PCF; next WAIT. If Redirect: PCF<=target, no request issued, stay REQ. IMemValid_i is ignored in REQ, including stale post-reset responses.
- WAIT: IMemReq_o=0.
  - Valid & Redirect: discard response, PCF<=target -> REQ.
  - Redirect without Valid: PCF<=target -> DROP.
  - Valid & Stall: capture Rdata into hold buffer -> HOLD.
  - Valid, no Stall: deliver {Rdata, PCF, PCF+4} into IF/ID, PCF<=PCF+4 -> REQ.
  - Otherwise stay WAIT.
- DROP: on Valid, discard -> REQ. A further Redirect updates PCF to the new target; a Redirect coinciding with Valid still goes to REQ.
- HOLD: Redirect: clear buffer, PCF<=target -> REQ. No Stall: deliver buffer into IF/ID, PCF<=PCF+4 -> REQ. Otherwise stay HOLD.
- Throughput: at most one instruction per 2 cycles with a 1-cycle-latency memory. At most one request is outstanding.
- IF/ID update priority, evaluated every cycle:
  1. FlushD_i: bubble (NOP_INSTR, ValidD=0; PCD and PCPlus4D unchanged).
  2. StallD_i: hold all IF/ID contents.
  3. Delivery this cycle: load {instr, PC, PC+4}, ValidD=1.
  4. Otherwise: bubble.
- Delivery never coincides with FlushD_i, because the controller asserts FlushD_i only together with PCSrcE_i.

Decomposition:
- Add to ucsbece154b_defines.vh: fetch state encodings (FETCH_REQ, FETCH_WAIT, FETCH_DROP, FETCH_HOLD, 2 bits) and NOP encoding.
- One sub-module is natural: ucsbece154b_ifid_reg, the IF/ID register with flush/stall/load/bubble priority and ValidD. The FSM, PCF and hold buffer stay in the top module.

Test Plan:
- Reset, then 1-cycle-latency memory returning 0x00500093 and 0x00100113 -> IMemAddr_o 0x10000 then 0x10004; InstrD_o=0x00500093, PCD_o=0x10000, PCPlus4D_o=0x10004, ValidD_o=1, RdD_o=1; bubble (ValidD_o=0) on alternate cycles.
- Request 0x10000, 3-cycle latency; PCSrcE_i=1 with target 0x10040 in the 2nd wait cycle -> response discarded (ValidD_o stays 0); next request address 0x10040.
- Response arrives with StallD_i=StallF_i=1 held for 2 cycles -> IF/ID unchanged, no new request; 1 cycle after stall drops, InstrD_o=buffered word, next IMemAddr_o=PC+4.
- FlushD_i=1 and StallD_i=1 in the same cycle -> InstrD_o=0x00000013, ValidD_o=0.
- PCF=0xFFFFFFFC, delivery occurs -> PCPlus4D_o=0, next IMemAddr_o=0.
- Assert reset mid-WAIT, then an IMemValid_i pulse 1 cycle after deassert -> pulse ignored, IMemAddr_o=0x10000, ValidD_o=0 until the next genuine response.
